uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Packet-level round-robin arbiter that shares the single UART transmit byte stream between up to 8 AXI-Stream byte sources. It sits between the requesting channels and the UART transmitter. Each granted packet is emitted as one header byte carrying the channel ID, followed by the packet payload. The grant is held until the source's tlast beat has been accepted.

## Interface
- NUM_CHANNELS, 4, number of requesters; legal range 2..8.
- aclk  in  1  clock.
- aresetn  in  1  reset; asynchronous, active-low.
- s_tvalid  in  NUM_CHANNELS  per-channel valid.
- s_tready  out  NUM_CHANNELS  per-channel ready; at most one bit high.
- s_tdata  in  NUM_CHANNELS*8  channel i byte on bits [8i+7:8i].
- s_tlast  in  NUM_CHANNELS  per-channel end-of-packet.
- m_tvalid  out  1  byte valid towards the UART transmitter.
- m_tready  in  1  UART transmitter ready.
- m_tdata  out  8  header or payload byte.
- m_tlast  out  1  high on the final payload byte of a packet.
- grant_id  out  3  currently or most recently granted channel.
- busy  out  1  high while in PAYLOAD.

## Operation
- States:
  - IDLE: no packet in progress.
  - PAYLOAD: granted packet being forwarded.
- Output register: m_tvalid/m_tdata/m_tlast form a single pipeline register. It can load when m_tvalid=0 or m_tready=1; call this "can_load".
- IDLE:
  - Arbitration happens only when any s_tvalid=1 and can_load.
  - The winner is the first requesting channel searching upward from (last_grant+1) mod NUM_CHANNELS, wrapping.
  - On the edge: load the header byte into the output register (m_tdata = 0xA0 | id, m_tlast=0, m_tvalid=1); set grant_id=id and last_grant=id; go to PAYLOAD.
  - No s_tready is asserted in IDLE.
- PAYLOAD:
  - s_tready[grant_id] = can_load; all other s_tready bits are 0.
  - Each accepted beat is copied into the output register, with m_tlast = s_tlast.
  - An accepted beat with s_tlast=1 returns the state to IDLE.
- If the granted source drops s_tvalid mid-packet, the grant is held and bubbles appear on m_tvalid. No re-arbitration happens before tlast.
- Requests from non-granted channels are ignored until IDLE. A pending request is never lost, because sources hold tvalid (AXI-Stream rule).
- When the output register drains with no new load, m_tvalid goes to 0.
- Reset values:
  - m_tvalid=0, m_tdata=0x00, m_tlast=0.
  - s_tready all 0, grant_id=0, busy=0, state=IDLE.
  - last_grant=NUM_CHANNELS-1, so channel 0 wins first.
- Reset mid-packet: the packet in flight is abandoned. The output register is cleared, and the first arbitration after release starts fresh from channel 0.
- Channels with index ≥ NUM_CHANNELS do not exist; header IDs are always < NUM_CHANNELS.

## Timing
- Arbitration to header on m_tvalid: 1 cycle, registered.
- Payload latency: source beat accepted at edge k appears on m_tdata after edge k.
- Throughput with a continuously ready sink: L+1 output beats for an L-byte packet, with no dead cycles.
  - The next packet's header may load on the cycle after the tlast beat is accepted.
  - That cycle is IDLE, with the output register draining in parallel.
- m_tvalid/m_tdata/m_tlast must stay stable while m_tvalid=1 and m_tready=0.
- s_tready depends combinationally on m_tready and m_tvalid only; it never depends on s_tvalid.
- busy changes on the same edges as the state.

## Structure
- Shared package axis_uart_pkg holds:
  - HEADER_MAGIC = 5'b10100;
  - MAX_CHANNELS = 8;
  - the state enum {IDLE, PAYLOAD}.
- Sub-module rr_priority_arbiter: combinational rotate-and-priority-encode. Inputs are the request vector and last_grant; outputs are winner id and any_req. last_grant is registered in uart_tx_arbiter.
- Verification code has no synthesis translate pragmas. Parameter range checks are done as elaboration-time assertions.

## Test plan
- Single channel: channel 2 sends a 3-byte packet 0x11,0x22,0x33 (tlast on 0x33), m_tready=1 -> m_tdata sequence 0xA2,0x11,0x22,0x33; m_tlast only on 0x33; 4 consecutive valid cycles.
- Fairness: all 4 channels request continuously with 1-byte packets -> headers 0xA0,0xA1,0xA2,0xA3,0xA0,… in strict rotation.
- Back-pressure: m_tready toggles 1/0 every cycle during a 5-byte packet -> no byte lost or duplicated; outputs stable while stalled; s_tready never high while the register is full and stalled.
- Source gap: granted channel 1 drops tvalid for 3 cycles mid-packet while channel 3 requests -> grant stays 1; channel 3 is served only after channel 1's tlast.
- Reset mid-packet: assert aresetn=0 during payload byte 2 -> all outputs at reset values immediately; after release, channel 0 requesting wins first with header 0xA0.
- Wrap-around: NUM_CHANNELS=8, last_grant=7, channels 0 and 5 request -> channel 0 granted, then channel 5.

Source files
------------

// File: rtl/axis_uart_pkg.sv
// Shared constants and state encoding for the UART transmit arbiter.
package axis_uart_pkg;

    // Top five bits of every header byte; the low three carry the channel id.
    localparam logic [4:0] HEADER_MAGIC = 5'b10100;
    localparam int         MAX_CHANNELS = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_e;

endpackage

// File: rtl/rr_priority_arbiter.sv
// Round-robin winner search: first requester strictly after last_grant,
// wrapping modulo NUM_CHANNELS. Purely combinational.
module rr_priority_arbiter
    import axis_uart_pkg::*;
#(
    parameter int NUM_CHANNELS = 4
) (
    input  logic [NUM_CHANNELS-1:0] req,
    input  logic [2:0]              last_grant,
    output logic [2:0]              winner,
    output logic                    any_req
);

    int idx;

    // Walk offsets from the farthest to the nearest so the nearest requester
    // after last_grant is the final assignment and therefore wins.
    always_comb begin
        winner  = last_grant;
        any_req = 1'b0;
        idx     = 0;
        for (int off = NUM_CHANNELS; off >= 1; off--) begin
            idx = (int'(last_grant) + off) % NUM_CHANNELS;
            if (req[idx]) begin
                winner  = 3'(idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter merging AXI-Stream byte sources into one
// UART byte stream, prefixing every packet with a channel-id header byte.
module uart_tx_arbiter
    import axis_uart_pkg::*;
#(
    parameter int NUM_CHANNELS = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NUM_CHANNELS-1:0]   s_tvalid,
    output logic [NUM_CHANNELS-1:0]   s_tready,
    input  logic [NUM_CHANNELS*8-1:0] s_tdata,
    input  logic [NUM_CHANNELS-1:0]   s_tlast,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [7:0]                m_tdata,
    output logic                      m_tlast,
    output logic [2:0]                grant_id,
    output logic                      busy
);

    if (NUM_CHANNELS < 2 || NUM_CHANNELS > MAX_CHANNELS) begin : g_bad_num_channels
        $error("uart_tx_arbiter: NUM_CHANNELS must be in 2..8");
    end

    state_e     state_q, state_d;
    logic       m_tvalid_q, m_tvalid_d;
    logic [7:0] m_tdata_q, m_tdata_d;
    logic       m_tlast_q, m_tlast_d;
    logic [2:0] grant_id_q, grant_id_d;
    logic [2:0] last_grant_q, last_grant_d;

    logic       can_load;
    logic       any_req;
    logic [2:0] win_id;
    logic       sel_valid;
    logic [7:0] sel_data;
    logic       sel_last;
    logic       accept;

    rr_priority_arbiter #(
        .NUM_CHANNELS(NUM_CHANNELS)
    ) u_rr (
        .req        (s_tvalid),
        .last_grant (last_grant_q),
        .winner     (win_id),
        .any_req    (any_req)
    );

    assign can_load = !m_tvalid_q || m_tready;

    // Ready is a function of registered state and the output slot only,
    // never of s_tvalid, so no combinational valid->ready path exists.
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ready
        assign s_tready[gi] = (state_q == PAYLOAD) && (grant_id_q == 3'(gi)) && can_load;
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = 8'h00;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (grant_id_q == 3'(i)) begin
                sel_valid = s_tvalid[i];
                sel_data  = s_tdata[8*i +: 8];
                sel_last  = s_tlast[i];
            end
        end
    end

    assign accept = (state_q == PAYLOAD) && can_load && sel_valid;

    always_comb begin
        state_d      = state_q;
        m_tvalid_d   = m_tvalid_q;
        m_tdata_d    = m_tdata_q;
        m_tlast_d    = m_tlast_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;

        // A slot that is free or being consumed empties unless reloaded below.
        if (can_load) begin
            m_tvalid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (any_req && can_load) begin
                    m_tvalid_d   = 1'b1;
                    m_tdata_d    = {HEADER_MAGIC, win_id};
                    m_tlast_d    = 1'b0;
                    grant_id_d   = win_id;
                    last_grant_d = win_id;
                    state_d      = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = sel_data;
                    m_tlast_d  = sel_last;
                    if (sel_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= 8'h00;
            m_tlast_q    <= 1'b0;
            grant_id_q   <= 3'd0;
            last_grant_q <= 3'(NUM_CHANNELS - 1);
        end else begin
            state_q      <= state_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            m_tlast_q    <= m_tlast_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign m_tvalid = m_tvalid_q;
    assign m_tdata  = m_tdata_q;
    assign m_tlast  = m_tlast_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q == PAYLOAD);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-channel byte sources, expected
// output beats queued at stimulus time and popped on each output handshake.
module tb_uart_tx_arbiter;

    localparam int N = 8;

    logic           aclk;
    logic           aresetn;
    logic [N-1:0]   s_tvalid;
    logic [N-1:0]   s_tready;
    logic [N*8-1:0] s_tdata;
    logic [N-1:0]   s_tlast;
    logic           m_tvalid;
    logic           m_tready;
    logic [7:0]     m_tdata;
    logic           m_tlast;
    logic [2:0]     grant_id;
    logic           busy;

    uart_tx_arbiter #(
        .NUM_CHANNELS(N)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    // Source model: per-channel circular buffer of {last, data}.
    logic [8:0] src_buf [N][32];
    int         src_wr  [N];
    int         src_rd  [N];
    int         gap     [N];

    logic [8:0] exp_q [$];

    logic       prev_stall;
    logic [9:0] prev_out;
    logic       toggle_rdy;
    int         cyc;
    int         fire_cnt;
    int         first_cyc;
    int         last_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic any_pending();
        logic p = 1'b0;
        for (int i = 0; i < N; i++) if (src_rd[i] != src_wr[i]) p = 1'b1;
        return p;
    endfunction

    task automatic drive();
        logic [8:0] b;
        for (int i = 0; i < N; i++) begin
            b = src_buf[i][src_rd[i] % 32];
            s_tvalid[i]       = (src_rd[i] != src_wr[i]) && (gap[i] == 0);
            s_tlast[i]        = (src_rd[i] != src_wr[i]) ? b[8] : 1'b0;
            s_tdata[8*i +: 8] = (src_rd[i] != src_wr[i]) ? b[7:0] : 8'h00;
        end
    endtask

    // Queue an L-byte packet on channel ch and its expected header + payload.
    task automatic push_pkt(input int ch, input int len, input logic [7:0] base);
        exp_q.push_back({1'b0, 8'hA0 | 8'(ch)});
        for (int k = 0; k < len; k++) begin
            src_buf[ch][src_wr[ch] % 32] = {(k == len - 1), base + 8'(k)};
            src_wr[ch]++;
            exp_q.push_back({(k == len - 1), base + 8'(k)});
        end
        drive();
    endtask

    task automatic step();
        logic       out_fire;
        logic [N-1:0] in_fire;
        logic [8:0] e;
        @(negedge aclk);
        out_fire = m_tvalid && m_tready;
        in_fire  = s_tvalid & s_tready;
        chk("tready_onehot", 32'($countones(s_tready) <= 1), 32'd1);
        if (m_tvalid && !m_tready) chk("tready_while_stalled", 32'(s_tready), 32'd0);
        if (prev_stall) chk("stall_stable", 32'({m_tvalid, m_tlast, m_tdata}), 32'(prev_out));
        prev_stall = m_tvalid && !m_tready;
        prev_out   = {m_tvalid, m_tlast, m_tdata};
        if (out_fire) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("out_beat", 32'({m_tlast, m_tdata}), 32'(e));
                $display("beat cyc=%0d data=%02h last=%0b grant=%0d", cyc, m_tdata, m_tlast, grant_id);
            end
            if (fire_cnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            fire_cnt++;
        end
        @(posedge aclk);
        cyc++;
        #1;
        for (int i = 0; i < N; i++) begin
            if (in_fire[i]) src_rd[i]++;
            if (gap[i] > 0) gap[i]--;
        end
        if (toggle_rdy) m_tready = !m_tready;
        drive();
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || any_pending() || m_tvalid) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk("timeout_beats_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
        chk({tag, "_m_tdata"},  32'(m_tdata),  32'd0);
        chk({tag, "_m_tlast"},  32'(m_tlast),  32'd0);
        chk({tag, "_s_tready"}, 32'(s_tready), 32'd0);
        chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
    endtask

    initial begin
        int start;
        int n;
        aresetn    = 1'b0;
        m_tready   = 1'b1;
        toggle_rdy = 1'b0;
        prev_stall = 1'b0;
        prev_out   = '0;
        cyc        = 0;
        fire_cnt   = 0;
        first_cyc  = 0;
        last_cyc   = 0;
        for (int i = 0; i < N; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
            gap[i]    = 0;
        end
        drive();
        repeat (3) @(posedge aclk);
        #1;
        check_reset_vals("por");
        aresetn = 1'b1;

        // Fairness: channels 0..3 each hold three 1-byte packets.
        for (int r = 0; r < 3; r++)
            for (int ch = 0; ch < 4; ch++)
                push_pkt(ch, 1, 8'h40 + 8'(ch * 4 + r));
        run_until_idle(200);

        // Single channel, sink always ready: four back-to-back output beats.
        fire_cnt = 0;
        src_buf[2][src_wr[2] % 32] = 9'h011; src_wr[2]++;
        src_buf[2][src_wr[2] % 32] = 9'h022; src_wr[2]++;
        src_buf[2][src_wr[2] % 32] = 9'h133; src_wr[2]++;
        exp_q.push_back(9'h0A2);
        exp_q.push_back(9'h011);
        exp_q.push_back(9'h022);
        exp_q.push_back(9'h133);
        drive();
        run_until_idle(100);
        chk("single_beats", 32'(fire_cnt), 32'd4);
        chk("single_span", 32'(last_cyc - first_cyc), 32'd3);

        // Back-pressure: sink ready toggles each cycle over a 5-byte packet.
        toggle_rdy = 1'b1;
        push_pkt(2, 5, 8'h50);
        run_until_idle(200);
        toggle_rdy = 1'b0;
        m_tready   = 1'b1;

        // Source gap: channel 1 stalls mid-packet while channel 3 waits.
        start = src_rd[1];
        push_pkt(1, 5, 8'h60);
        n = 0;
        while (src_rd[1] < start + 2 && n < 50) begin step(); n++; end
        chk("gap_reached", 32'(src_rd[1] - start), 32'd2);
        gap[1] = 3;
        push_pkt(3, 2, 8'h70);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("gap_grant_held", 32'(grant_id), 32'd1);
            chk("gap_busy", 32'(busy), 32'd1);
        end
        run_until_idle(200);
        chk("gap_final_grant", 32'(grant_id), 32'd3);

        // Wrap-around: after channel 7, channel 0 beats channel 5.
        push_pkt(7, 1, 8'hC0);
        run_until_idle(100);
        push_pkt(0, 2, 8'hD0);
        push_pkt(5, 2, 8'hD8);
        run_until_idle(100);
        chk("wrap_final_grant", 32'(grant_id), 32'd5);

        // Reset mid-packet: abandon channel 2's packet, restart from channel 0.
        start = src_rd[2];
        push_pkt(2, 4, 8'h80);
        n = 0;
        while (src_rd[2] < start + 1 && n < 50) begin step(); n++; end
        chk("reset_reached", 32'(src_rd[2] - start), 32'd1);
        aresetn = 1'b0;
        #1;
        check_reset_vals("midrst");
        exp_q.delete();
        for (int i = 0; i < N; i++) src_rd[i] = src_wr[i];
        drive();
        prev_stall = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        push_pkt(0, 2, 8'h90);
        push_pkt(3, 1, 8'h98);
        run_until_idle(100);
        chk("post_reset_grant", 32'(grant_id), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
